// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ADC ramp convert,
// then one-hot row reads; single-shot or free-running frames.
module pixel_seq_ctrl #(
    parameter int N_ROWS    = 4,
    parameter int ERASE_CYC = 5,
    parameter int EXP_W     = 8,
    parameter int DATA_W    = 8,
    parameter int READ_CYC  = 2,
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [EXP_W-1:0]  expose_time,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic [N_ROWS-1:0] read,
    output logic [DATA_W-1:0] adc_count,
    output logic [RW-1:0]     row_idx,
    output logic              busy,
    output logic              frame_done
);

    localparam int EC_W = $clog2(ERASE_CYC + 1);
    localparam int RC_W = $clog2(READ_CYC + 1);
    localparam int CW0  = (EC_W > RC_W) ? EC_W : RC_W;
    localparam int CW   = (CW0 > EXP_W) ? CW0 : EXP_W;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_adc;
    logic [EXP_W-1:0]  r_exp;
    logic              r_done;

    state_t            w_state_n;
    logic [CW-1:0]     w_cnt_n;
    logic [RW-1:0]     w_row_n;
    logic [DATA_W-1:0] w_adc_n;
    logic [EXP_W-1:0]  w_exp_n;
    logic              w_done_n;
    logic [EXP_W-1:0]  w_exp_lat;

    // A zero exposure request still gets one expose cycle
    assign w_exp_lat = (expose_time == '0) ? EXP_W'(1) : expose_time;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_adc   <= '0;
            r_exp   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_row   <= w_row_n;
            r_adc   <= w_adc_n;
            r_exp   <= w_exp_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_row_n   = r_row;
        w_adc_n   = '0;
        w_exp_n   = r_exp;
        w_done_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                w_row_n = '0;
                if (start) begin
                    w_state_n = ERASE;
                    w_exp_n   = w_exp_lat;
                end
            end
            ERASE: begin
                if (r_cnt == CW'(ERASE_CYC - 1)) begin
                    w_state_n = EXPOSE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            EXPOSE: begin
                if (r_cnt == CW'(r_exp) - CW'(1)) begin
                    w_state_n = CONVERT;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            CONVERT: begin
                if (r_adc == '1) begin
                    w_state_n = READ;
                    w_row_n   = '0;
                    w_cnt_n   = '0;
                end else begin
                    w_adc_n = r_adc + DATA_W'(1);
                end
            end
            READ: begin
                if (r_cnt == CW'(READ_CYC - 1)) begin
                    w_cnt_n = '0;
                    if (r_row == RW'(N_ROWS - 1)) begin
                        w_row_n   = '0;
                        w_done_n  = 1'b1;
                        w_state_n = cont_mode ? ERASE : IDLE;
                        if (cont_mode) w_exp_n = w_exp_lat;
                    end else begin
                        w_row_n = r_row + RW'(1);
                    end
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
                w_row_n   = '0;
            end
        endcase
    end

    assign erase      = (r_state == ERASE);
    assign expose     = (r_state == EXPOSE);
    assign convert    = (r_state == CONVERT);
    assign read       = (r_state == READ) ? (N_ROWS'(1) << r_row) : '0;
    assign adc_count  = r_adc;
    assign row_idx    = r_row;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_done;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed bench for pixel_seq_ctrl: 4-row and 1-row builds, DATA_W=4,
// frames checked cycle by cycle against a phase-position model.
module tb_pixel_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       cont_mode = 1'b0;
    logic [7:0] expose_time = 8'd0;

    logic       erase, expose, convert, busy, frame_done;
    logic [3:0] read, adc_count;
    logic [1:0] row_idx;

    logic       erase1, expose1, convert1, busy1, frame_done1;
    logic [0:0] read1, row_idx1;
    logic [3:0] adc_count1;

    logic [14:0] obs;
    int n_pass = 0;
    int n_total = 0;

    assign obs = {erase, expose, convert, read, adc_count,
                  row_idx, busy, frame_done};

    always #5 clk = ~clk;

    pixel_seq_ctrl #(
        .N_ROWS(4), .ERASE_CYC(5), .EXP_W(8), .DATA_W(4), .READ_CYC(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cont_mode(cont_mode), .expose_time(expose_time),
        .erase(erase), .expose(expose), .convert(convert),
        .read(read), .adc_count(adc_count), .row_idx(row_idx),
        .busy(busy), .frame_done(frame_done)
    );

    pixel_seq_ctrl #(
        .N_ROWS(1), .ERASE_CYC(5), .EXP_W(8), .DATA_W(4), .READ_CYC(2)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .cont_mode(1'b0), .expose_time(expose_time),
        .erase(erase1), .expose(expose1), .convert(convert1),
        .read(read1), .adc_count(adc_count1), .row_idx(row_idx1),
        .busy(busy1), .frame_done(frame_done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle c of a 4-row frame with exposure e
    function automatic logic [14:0] model(int c, int e, bit done_in);
        logic       m_er, m_ex, m_cv;
        logic [3:0] m_rd, m_adc;
        logic [1:0] m_row;
        m_er = 0; m_ex = 0; m_cv = 0;
        m_rd = '0; m_adc = '0; m_row = '0;
        if (c < 5) m_er = 1;
        else if (c < 5 + e) m_ex = 1;
        else if (c < 21 + e) begin
            m_cv  = 1;
            m_adc = 4'(c - 5 - e);
        end else begin
            m_row = 2'((c - 21 - e) / 2);
            m_rd  = 4'd1 << m_row;
        end
        return {m_er, m_ex, m_cv, m_rd, m_adc, m_row, 1'b1,
                (done_in && c == 0)};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_total++;
        if (obs !== 15'h0)
            $display("FAIL reset_hold got %h exp %h", obs, 15'h0);
        else n_pass++;
        reset = 1'b1;
        repeat (5) tick();
        n_total++;
        if (obs !== 15'h0)
            $display("FAIL reset_idle got %h exp %h", obs, 15'h0);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        expose_time = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 39; c++) begin
            n_total++;
            if (obs !== model(c, 10, 0))
                $display("FAIL single c=%0d got %h exp %h",
                         c, obs, model(c, 10, 0));
            else n_pass++;
            tick();
        end
        n_total++;
        if (obs !== 15'h1)
            $display("FAIL single_done got %h exp %h", obs, 15'h1);
        else n_pass++;
        tick();
        n_total++;
        if (obs !== 15'h0)
            $display("FAIL single_idle got %h exp %h", obs, 15'h0);
        else n_pass++;
    endtask

    task automatic test_expose_zero();
        expose_time = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n_total++;
            if (obs !== model(c, 1, 0))
                $display("FAIL exp0 c=%0d got %h exp %h",
                         c, obs, model(c, 1, 0));
            else n_pass++;
            tick();
        end
        n_total++;
        if (obs !== 15'h1)
            $display("FAIL exp0_done got %h exp %h", obs, 15'h1);
        else n_pass++;
        tick();
    endtask

    task automatic test_expose_change();
        expose_time = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            n_total++;
            if (obs !== model(c, 3, 0))
                $display("FAIL expchg c=%0d got %h exp %h",
                         c, obs, model(c, 3, 0));
            else n_pass++;
            if (c == 6) expose_time = 8'd20;
            tick();
        end
        n_total++;
        if (obs !== 15'h1)
            $display("FAIL expchg_done got %h exp %h", obs, 15'h1);
        else n_pass++;
        tick();
    endtask

    task automatic test_continuous();
        expose_time = 8'd4;
        cont_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 33; c++) begin
                n_total++;
                if (obs !== model(c, 4, f > 0))
                    $display("FAIL cont f=%0d c=%0d got %h exp %h",
                             f, c, obs, model(c, 4, f > 0));
                else n_pass++;
                if (f == 2 && c == 10) cont_mode = 1'b0;
                tick();
            end
        end
        n_total++;
        if (obs !== 15'h1)
            $display("FAIL cont_end got %h exp %h", obs, 15'h1);
        else n_pass++;
        tick();
        n_total++;
        if (obs !== 15'h0)
            $display("FAIL cont_idle got %h exp %h", obs, 15'h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        expose_time = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        n_total++;
        if ({convert, adc_count} !== 5'h17)
            $display("FAIL mid_pre got %h exp %h",
                     {convert, adc_count}, 5'h17);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_total++;
        if (obs !== 15'h0)
            $display("FAIL mid_reset got %h exp %h", obs, 15'h0);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (obs !== 15'h0)
            $display("FAIL mid_release got %h exp %h", obs, 15'h0);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 31; c++) begin
            n_total++;
            if (obs !== model(c, 2, 0))
                $display("FAIL mid_frame c=%0d got %h exp %h",
                         c, obs, model(c, 2, 0));
            else n_pass++;
            tick();
        end
        n_total++;
        if (obs !== 15'h1)
            $display("FAIL mid_done got %h exp %h", obs, 15'h1);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        expose_time = 8'd1;
        start = 1'b1;
        tick();
        for (int c = 0; c < 30; c++) begin
            n_total++;
            if (obs !== model(c, 1, 0))
                $display("FAIL b2b c=%0d got %h exp %h",
                         c, obs, model(c, 1, 0));
            else n_pass++;
            tick();
        end
        n_total++;
        if (obs !== 15'h1)
            $display("FAIL b2b_idle got %h exp %h", obs, 15'h1);
        else n_pass++;
        tick();
        n_total++;
        if (obs !== model(0, 1, 0))
            $display("FAIL b2b_restart got %h exp %h",
                     obs, model(0, 1, 0));
        else n_pass++;
        start = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_row();
        expose_time = 8'd2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 25; c++) begin
            n_total++;
            if ({erase1, expose1, convert1, read1, row_idx1, busy1}
                !== {c < 5, c >= 5 && c < 7, c >= 7 && c < 23,
                     c >= 23, 1'b0, 1'b1})
                $display("FAIL row1 c=%0d got %b", c,
                         {erase1, expose1, convert1, read1,
                          row_idx1, busy1});
            else n_pass++;
            tick();
        end
        n_total++;
        if ({read1, busy1, frame_done1} !== 3'b001)
            $display("FAIL row1_done got %b exp %b",
                     {read1, busy1, frame_done1}, 3'b001);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_expose_zero();
        test_expose_change();
        test_continuous();
        test_reset_mid();
        test_back_to_back();
        test_single_row();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
